// File: rtl/aq_vfmau_mult_53x53_seq.sv
// Sequential 53x53 unsigned multiplier built on an external 53x27 partial multiplier.
// The low 27 bits of src1 are multiplied first, then the high 26 bits, which are accumulated at <<27.
module aq_vfmau_mult_53x53_seq #(
    parameter int PMUL_LAT = 0
) (
    input  logic          forever_cpuclk,
    input  logic          vfmau_rst,
    input  logic          mult_flush,
    input  logic          mult_req_vld,
    output logic          mult_req_rdy,
    input  logic [52:0]   mult_src0,
    input  logic [52:0]   mult_src1,
    output logic [52:0]   pmul_a,
    output logic [26:0]   pmul_b,
    input  logic [83:0]   pmul_out0,
    input  logic [83:0]   pmul_out1,
    output logic          mult_rslt_vld,
    input  logic          mult_rslt_rdy,
    output logic [105:0]  mult_rslt
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [0:0] WAIT_LAST = 1'(PMUL_LAT);

    state_t         state_reg, state_next;
    logic [0:0]     wait_reg;
    logic [52:0]    src0_reg, src1_reg;
    logic [105:0]   acc_reg;
    logic [83:0]    psum;
    logic           dwell_done;
    logic           accept;

    // The partial product arrives as two redundant words; only their sum is meaningful.
    assign psum       = pmul_out0 + pmul_out1;
    assign dwell_done = (wait_reg == WAIT_LAST);
    assign accept     = (state_reg == IDLE) && mult_req_vld && !mult_flush;

    always_ff @(posedge forever_cpuclk) begin
        if (vfmau_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (mult_flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (mult_req_vld)  state_next = LO;
                LO:      if (dwell_done)    state_next = HI;
                HI:      if (dwell_done)    state_next = DONE;
                DONE:    if (mult_rslt_rdy) state_next = IDLE;
                default:                    state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        mult_req_rdy  = 1'b0;
        mult_rslt_vld = 1'b0;
        mult_rslt     = '0;
        pmul_a        = '0;
        pmul_b        = '0;
        case (state_reg)
            IDLE: mult_req_rdy = !mult_flush;
            LO: begin
                pmul_a = src0_reg;
                pmul_b = src1_reg[26:0];
            end
            HI: begin
                pmul_a = src0_reg;
                pmul_b = {1'b0, src1_reg[52:27]};
            end
            DONE: begin
                mult_rslt_vld = 1'b1;
                mult_rslt     = acc_reg;
            end
            default: ;
        endcase
    end

    // Wait counter restarts on every state change so each dwell lasts PMUL_LAT+1 cycles.
    always_ff @(posedge forever_cpuclk) begin
        if (vfmau_rst) begin
            wait_reg <= '0;
        end else if (state_next != state_reg) begin
            wait_reg <= '0;
        end else if (state_reg == LO || state_reg == HI) begin
            wait_reg <= wait_reg + 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (vfmau_rst) begin
            src0_reg <= '0;
            src1_reg <= '0;
            acc_reg  <= '0;
        end else if (accept) begin
            src0_reg <= mult_src0;
            src1_reg <= mult_src1;
            acc_reg  <= '0;
        end else if (!mult_flush && dwell_done) begin
            if (state_reg == LO) begin
                acc_reg <= {22'b0, psum};
            end else if (state_reg == HI) begin
                acc_reg <= acc_reg + ({22'b0, psum} << 27);
            end
        end
    end

endmodule

// File: tb/tb_aq_vfmau_mult_53x53_seq.sv
// Directed bench for the sequential 53x53 multiplier: one zero-latency instance for the main
// sequence and one PMUL_LAT=1 instance fed by a registered partial-multiplier model.
module tb_aq_vfmau_mult_53x53_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with combinational partial multiplier (PMUL_LAT=0)
    logic          rst, flush, req_vld, req_rdy, rslt_vld, rslt_rdy;
    logic [52:0]   src0, src1, pmul_a;
    logic [26:0]   pmul_b;
    logic [83:0]   out0, out1, prod0;
    logic [105:0]  rslt;

    // Instance with one-cycle partial multiplier (PMUL_LAT=1)
    logic          rst_1, flush_1, req_vld_1, req_rdy_1, rslt_vld_1, rslt_rdy_1;
    logic [52:0]   src0_1, src1_1, pmul_a_1;
    logic [26:0]   pmul_b_1;
    logic [83:0]   out0_1, out1_1, prod1;
    logic [105:0]  rslt_1;

    logic [83:0]   rnd;
    logic [105:0]  exp_q[$];
    logic [105:0]  last_rslt;
    logic [26:0]   lo_b, hi_b;
    int            tests = 0;
    int            fails = 0;

    aq_vfmau_mult_53x53_seq #(.PMUL_LAT(0)) dut (
        .forever_cpuclk(clk), .vfmau_rst(rst), .mult_flush(flush),
        .mult_req_vld(req_vld), .mult_req_rdy(req_rdy),
        .mult_src0(src0), .mult_src1(src1),
        .pmul_a(pmul_a), .pmul_b(pmul_b), .pmul_out0(out0), .pmul_out1(out1),
        .mult_rslt_vld(rslt_vld), .mult_rslt_rdy(rslt_rdy), .mult_rslt(rslt)
    );

    aq_vfmau_mult_53x53_seq #(.PMUL_LAT(1)) dut_1 (
        .forever_cpuclk(clk), .vfmau_rst(rst_1), .mult_flush(flush_1),
        .mult_req_vld(req_vld_1), .mult_req_rdy(req_rdy_1),
        .mult_src0(src0_1), .mult_src1(src1_1),
        .pmul_a(pmul_a_1), .pmul_b(pmul_b_1), .pmul_out0(out0_1), .pmul_out1(out1_1),
        .mult_rslt_vld(rslt_vld_1), .mult_rslt_rdy(rslt_rdy_1), .mult_rslt(rslt_1)
    );

    // Partial multiplier models: product split into a random word and its complement.
    always @(negedge clk) begin
        logic [95:0] r96;
        r96 = {$urandom, $urandom, $urandom};
        rnd <= r96[83:0];
    end
    assign prod0 = {31'b0, pmul_a} * {57'b0, pmul_b};
    assign out0  = rnd;
    assign out1  = prod0 - rnd;
    assign prod1 = {31'b0, pmul_a_1} * {57'b0, pmul_b_1};
    always @(posedge clk) begin
        out0_1 <= rnd;
        out1_1 <= prod1 - rnd;
    end

    task automatic check(input string tag, input logic [105:0] obs, input logic [105:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one operation on the PMUL_LAT=0 instance; entered and left on a negedge in IDLE.
    task automatic do_op(input logic [52:0] a, input logic [52:0] b, input int hold);
        logic [105:0] exp, snap;
        int k;
        check("req_rdy_idle", {105'b0, req_rdy}, 106'd1);
        req_vld = 1'b1; src0 = a; src1 = b; rslt_rdy = 1'b0;
        @(posedge clk);
        exp_q.push_back({53'b0, a} * {53'b0, b});
        @(negedge clk);
        req_vld = 1'b0; src0 = '0; src1 = '0;
        k = 1;
        while (!rslt_vld && k < 20) begin
            if (k == 1) lo_b = pmul_b;
            if (k == 2) hi_b = pmul_b;
            @(negedge clk);
            k++;
        end
        check("latency", 106'(k), 106'd3);
        snap = rslt;
        for (int i = 0; i < hold; i++) begin
            check("hold_req_rdy", {105'b0, req_rdy}, 106'd0);
            check("hold_pmul_a", {53'b0, pmul_a}, 106'd0);
            check("hold_pmul_b", {79'b0, pmul_b}, 106'd0);
            @(negedge clk);
            check("hold_vld", {105'b0, rslt_vld}, 106'd1);
            check("hold_rslt", rslt, snap);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("product", rslt, exp);
        last_rslt = rslt;
        $display("[TB] op a=%h b=%h hold=%0d product=%h", a, b, hold, rslt);
        rslt_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rslt_rdy = 1'b0;
        check("post_req_rdy", {105'b0, req_rdy}, 106'd1);
        check("post_vld", {105'b0, rslt_vld}, 106'd0);
    endtask

    initial begin
        logic [63:0]  ra, rb;
        logic [52:0]  a1, b1;
        logic [26:0]  bs[4];
        logic [105:0] c;
        int k;

        rst = 1'b1; flush = 1'b0; req_vld = 1'b0; rslt_rdy = 1'b0; src0 = '0; src1 = '0;
        rst_1 = 1'b1; flush_1 = 1'b0; req_vld_1 = 1'b0; rslt_rdy_1 = 1'b0; src0_1 = '0; src1_1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst_1 = 1'b0;
        #1;
        check("rst_req_rdy", {105'b0, req_rdy}, 106'd1);
        check("rst_vld", {105'b0, rslt_vld}, 106'd0);
        check("rst_rslt", rslt, 106'd0);
        check("rst_pmul_a", {53'b0, pmul_a}, 106'd0);
        check("rst_pmul_b", {79'b0, pmul_b}, 106'd0);
        @(negedge clk);

        do_op(53'd1, 53'd1, 0);
        check("one_times_one", last_rslt, 106'd1);

        do_op('1, '1, 0);
        c = '1 - (106'd1 << 54) + 106'd2;
        check("max_times_max", last_rslt, c);

        do_op(53'd3, 53'd1 << 27, 0);
        check("lo_pmul_b", {79'b0, lo_b}, 106'd0);
        check("hi_pmul_b", {79'b0, hi_b}, 106'd1);
        check("shift_product", last_rslt, 106'd3 << 27);

        do_op(53'h1_2345_6789_ABCD, 53'h0_FEDC_BA98_7654, 5);

        // Flush while in HI: operation must vanish without a result.
        req_vld = 1'b1; src0 = 53'd11; src1 = 53'd13;
        @(posedge clk);
        @(negedge clk);
        req_vld = 1'b0;
        @(negedge clk);
        check("flush_in_hi", {79'b0, pmul_b}, 106'd0);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_vld", {105'b0, rslt_vld}, 106'd0);
        check("flush_req_rdy", {105'b0, req_rdy}, 106'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_no_vld", {105'b0, rslt_vld}, 106'd0);
        end
        $display("[TB] op a=%h b=%h flushed in HI", 53'd11, 53'd13);
        do_op(53'd5, 53'd7, 0);
        check("after_flush", last_rslt, 106'd35);

        for (int n = 0; n < 4; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            do_op(ra[52:0], rb[52:0], n % 3);
        end

        // PMUL_LAT=1 instance: two-cycle dwells, result at T+5.
        a1 = 53'h1F_0F0F_0F0F_0F0F; b1 = 53'h15_5555_AAAA_5555;
        req_vld_1 = 1'b1; src0_1 = a1; src1_1 = b1;
        @(posedge clk);
        @(negedge clk);
        req_vld_1 = 1'b0;
        k = 1;
        while (!rslt_vld_1 && k < 20) begin
            if (k <= 4) bs[k-1] = pmul_b_1;
            @(negedge clk);
            k++;
        end
        check("lat1_latency", 106'(k), 106'd5);
        check("lat1_lo_b0", {79'b0, bs[0]}, {79'b0, b1[26:0]});
        check("lat1_lo_b1", {79'b0, bs[1]}, {79'b0, b1[26:0]});
        check("lat1_hi_b0", {79'b0, bs[2]}, {80'b0, b1[52:27]});
        check("lat1_hi_b1", {79'b0, bs[3]}, {80'b0, b1[52:27]});
        check("lat1_product", rslt_1, {53'b0, a1} * {53'b0, b1});
        $display("[TB] lat1 op a=%h b=%h product=%h", a1, b1, rslt_1);
        rslt_rdy_1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rslt_rdy_1 = 1'b0;

        // Reset during LO discards the operation.
        req_vld_1 = 1'b1; src0_1 = 53'd9; src1_1 = 53'd9;
        @(posedge clk);
        @(negedge clk);
        req_vld_1 = 1'b0;
        rst_1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_1 = 1'b0;
        #1;
        check("lat1_rst_vld", {105'b0, rslt_vld_1}, 106'd0);
        check("lat1_rst_rslt", rslt_1, 106'd0);
        check("lat1_rst_pmul_a", {53'b0, pmul_a_1}, 106'd0);
        check("lat1_rst_pmul_b", {79'b0, pmul_b_1}, 106'd0);
        check("lat1_rst_req_rdy", {105'b0, req_rdy_1}, 106'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("lat1_rst_no_vld", {105'b0, rslt_vld_1}, 106'd0);
        end
        $display("[TB] lat1 op a=%h b=%h reset in LO", 53'd9, 53'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
